conv3x3_mac: RTL and testbench
==============================

Name: conv3x3_mac

Overview:
- Downstream consumer of the 3x3 line-buffer stage: receives one flattened 3x3 pixel window per valid cycle (stride 1, no padding).
- Multiplies the window by a 9-tap signed kernel and reduces it through a 3-stage pipeline.
- Emits one signed result per window, tagged with end-of-line and end-of-frame markers, for the write-back stage.
- Kernel coefficients are loaded serially at runtime.

Parameters:
- input_y, 6, frame width/height in pixels (square frame); outputs per line = input_y-2.
- DATA_W, 8, unsigned pixel width.
- COEF_W, 8, signed coefficient width.
- OUT_W, 20, signed output width; the result saturates to this width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- sof  in  1  start of frame; clears output position counters
- win_valid  in  1  window valid (driven by line buffer control output_valid)
- win_data  in  9*DATA_W  pixels; tap k = win_data[k*DATA_W +: DATA_W], k = row*3+col, k=0 top-left
- coef_load  in  1  coefficient write strobe
- coef_data  in  COEF_W  signed coefficient, written in tap order 0..8
- coef_ready  out  1  all 9 coefficients loaded; kernel active
- out_valid  out  1  result valid
- out_data  out  OUT_W  signed saturated convolution result
- out_eol  out  1  result is last in its output line
- out_eof  out  1  result is last of the frame
- drop_err  out  1  sticky: a window arrived while coef_ready=0
- state  out  1  debug: 0=S_LOAD, 1=S_RUN

Behaviour:
- Reset (rst=0, asynchronous): state=S_LOAD, coef index=0, all coefficients=0, coef_ready=0, out_valid=0, out_data=0, out_eol=0, out_eof=0, drop_err=0, counters=0, pipeline valid bits=0.
- S_LOAD:
  - Each coef_load cycle writes coef_data to tap[index] and increments index.
  - On the 9th write (index=8), index returns to 0, coef_ready=1 from the next cycle, and state moves to S_RUN.
- S_RUN:
  - coef_load writes tap 0, sets index=1, clears coef_ready, and returns to S_LOAD.
  - Results already in the pipeline still complete using the coefficients they captured.
- Windows in S_LOAD: a window with win_valid=1 while coef_ready=0 is dropped (not counted, no output) and sets drop_err. drop_err clears only on reset.
- Pipeline (latency exactly 3 cycles; win_valid at edge N gives out_valid during the cycle after edge N+3; throughput 1 window/cycle, no backpressure):
  - Stage 1: 9 products. Each pixel is zero-extended to DATA_W+1 signed and multiplied by its coefficient, giving DATA_W+COEF_W+1 bits.
  - Stage 2: three row partial sums, 2 guard bits each.
  - Stage 3: final sum, 4 guard bits. Clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Position tagging at stage-1 entry: col and row counters (range 0..input_y-3) are captured with each window and travel down the pipeline.
  - out_eol = (col == input_y-3).
  - out_eof = out_eol AND (row == input_y-3).
  - After an accepted window, col increments; at its max, col wraps to 0 and row increments; at row max, row wraps to 0.
- sof:
  - sof=1 clears col and row before tagging.
  - sof and win_valid in the same cycle: that window is tagged col=0,row=0, and counters become col=1,row=0.
  - sof mid-frame abandons the frame position; in-flight results keep their old tags.
- out_eol, out_eof, and out_data are meaningful only while out_valid=1. They hold their last values while out_valid=0.
- coef_load and win_valid in the same S_RUN cycle: the window is accepted using the old coefficient set, and the load takes effect for later windows.

Decomposition:
- Shared package conv_pkg holds:
  - state encodings S_LOAD and S_RUN
  - the tap-index width constant
  - a saturation width helper constant
- Natural sub-module: conv3x3_adder_tree, holding pipeline stages 2-3 plus saturation. It takes 9 products and a valid/tag sideband and returns the saturated sum.
- The top level keeps the coefficient registers, the FSM, the position counters, and stage 1.

Test Plan:
- Identity kernel (tap4=1, others 0), window pixels 1..9 -> out_data=5 exactly 3 cycles after win_valid; coef_ready=1 after the 9th load.
- All-ones kernel, all pixels 255 -> out_data=2295. Kernel all -128, pixels 255 -> out_data=-293760 (no saturation at OUT_W=20).
- Saturation: OUT_W=16, all coefficients 127, pixels 255 -> out_data=32767. All coefficients -128 -> out_data=-32768.
- Window stream with input_y=6, sof on first window, 16 back-to-back windows:
  - out_eol on results 4, 8, 12, 16.
  - out_eof only on result 16.
  - A 17th window is tagged col=0,row=0.
- Window with win_valid before kernel load -> no out_valid, drop_err=1. Reload the kernel mid-stream -> in-flight results use the old kernel, later results use the new one, coef_ready=0 during reload.
- Assert rst low mid-frame for 1 cycle with 2 results in flight -> all outputs 0 immediately, no stale out_valid, state=S_LOAD.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the 3x3 convolution MAC.
package conv_pkg;

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam int NUM_TAPS  = 9;
    localparam int TAP_IDX_W = 4;
    localparam int ROW_GUARD = 2;
    localparam int SUM_GUARD = 4;

    // Width of the unsaturated kernel sum, given the width of one product.
    function automatic int sat_sum_width(input int prod_w);
        return prod_w + SUM_GUARD;
    endfunction

endpackage

// File: rtl/conv3x3_adder_tree.sv
// Pipeline stages 2-3: row partial sums, final sum, clamp to the output width.
module conv3x3_adder_tree
    import conv_pkg::*;
#(
    parameter int P_W   = 17,
    parameter int OUT_W = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_eol,
    input  logic                    in_eof,
    input  logic signed [P_W-1:0]   prod [NUM_TAPS],
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_eol,
    output logic                    out_eof
);

    localparam int ROW_W = P_W + ROW_GUARD;
    localparam int SUM_W = sat_sum_width(P_W);
    localparam int EXT_W = (SUM_W > OUT_W) ? SUM_W : OUT_W;
    localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [ROW_W-1:0] row_d [3];
    logic signed [ROW_W-1:0] row_q [3];
    logic                    s2_valid, s2_eol, s2_eof;
    logic signed [SUM_W-1:0] sum_d;
    logic signed [EXT_W-1:0] sum_ext;
    logic signed [EXT_W-1:0] sat_d;

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            row_d[r] = ROW_W'(prod[3*r]) + ROW_W'(prod[3*r+1]) + ROW_W'(prod[3*r+2]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_eol   <= 1'b0;
            s2_eof   <= 1'b0;
            for (int r = 0; r < 3; r++) row_q[r] <= '0;
        end else begin
            s2_valid <= in_valid;
            if (in_valid) begin
                s2_eol <= in_eol;
                s2_eof <= in_eof;
                for (int r = 0; r < 3; r++) row_q[r] <= row_d[r];
            end
        end
    end

    always_comb begin
        sum_d   = SUM_W'(row_q[0]) + SUM_W'(row_q[1]) + SUM_W'(row_q[2]);
        sum_ext = EXT_W'(sum_d);
        if (sum_ext > SAT_MAX)
            sat_d = SAT_MAX;
        else if (sum_ext < SAT_MIN)
            sat_d = SAT_MIN;
        else
            sat_d = sum_ext;
    end

    // Data and tags only move on valid results so they hold between them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_data <= sat_d[OUT_W-1:0];
                out_eol  <= s2_eol;
                out_eof  <= s2_eof;
            end
        end
    end

endmodule

// File: rtl/conv3x3_mac.sv
// 3x3 window x signed kernel MAC with serial coefficient load and position tagging.
//   state  | meaning
//   S_LOAD | coefficients being written serially; windows are dropped
//   S_RUN  | kernel complete; windows accepted into the pipeline
module conv3x3_mac
    import conv_pkg::*;
#(
    parameter int input_y = 6,
    parameter int DATA_W  = 8,
    parameter int COEF_W  = 8,
    parameter int OUT_W   = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sof,
    input  logic                       win_valid,
    input  logic [NUM_TAPS*DATA_W-1:0] win_data,
    input  logic                       coef_load,
    input  logic signed [COEF_W-1:0]   coef_data,
    output logic                       coef_ready,
    output logic                       out_valid,
    output logic signed [OUT_W-1:0]    out_data,
    output logic                       out_eol,
    output logic                       out_eof,
    output logic                       drop_err,
    output logic                       state
);

    localparam int P_W   = DATA_W + COEF_W + 1;
    localparam int POS_N = input_y - 2;
    localparam int POS_W = (POS_N > 1) ? $clog2(POS_N) : 1;
    localparam logic [POS_W-1:0]     POS_MAX  = POS_W'(POS_N - 1);
    localparam logic [TAP_IDX_W-1:0] LAST_TAP = TAP_IDX_W'(NUM_TAPS - 1);

    state_t                  state_q, state_d;
    logic [TAP_IDX_W-1:0]    idx_q, idx_d, wr_idx;
    logic signed [COEF_W-1:0] coef_q [NUM_TAPS];
    logic [POS_W-1:0]        col_q, row_q, col_cur, row_cur;
    logic                    accept;
    logic signed [P_W-1:0]   prod_d [NUM_TAPS];
    logic signed [P_W-1:0]   prod_q [NUM_TAPS];
    logic                    s1_valid, s1_eol, s1_eof;

    assign coef_ready = (state_q == S_RUN);
    assign state      = state_q;
    assign accept     = win_valid & coef_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_LOAD;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (coef_load) begin
            if (state_q == S_LOAD) begin
                if (idx_q == LAST_TAP) begin
                    idx_d   = '0;
                    state_d = S_RUN;
                end else begin
                    idx_d = idx_q + TAP_IDX_W'(1);
                end
            end else begin
                idx_d   = TAP_IDX_W'(1);
                state_d = S_LOAD;
            end
        end
    end

    // A load while running restarts the kernel at tap 0.
    assign wr_idx = (state_q == S_RUN) ? '0 : idx_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_TAPS; k++) coef_q[k] <= '0;
        end else if (coef_load) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                if (wr_idx == TAP_IDX_W'(k)) coef_q[k] <= coef_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            drop_err <= 1'b0;
        else if (win_valid && !coef_ready)
            drop_err <= 1'b1;
    end

    always_comb begin
        col_cur = sof ? '0 : col_q;
        row_cur = sof ? '0 : row_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            if (col_cur == POS_MAX) begin
                col_q <= '0;
                row_q <= (row_cur == POS_MAX) ? '0 : row_cur + POS_W'(1);
            end else begin
                col_q <= col_cur + POS_W'(1);
                row_q <= row_cur;
            end
        end else if (sof) begin
            col_q <= '0;
            row_q <= '0;
        end
    end

    // Pixels are unsigned, so widen with a zero sign bit before the signed multiply.
    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            prod_d[k] = P_W'($signed({1'b0, win_data[k*DATA_W +: DATA_W]})) * P_W'(coef_q[k]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_eol   <= 1'b0;
            s1_eof   <= 1'b0;
            for (int k = 0; k < NUM_TAPS; k++) prod_q[k] <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_eol <= (col_cur == POS_MAX);
                s1_eof <= (col_cur == POS_MAX) && (row_cur == POS_MAX);
                for (int k = 0; k < NUM_TAPS; k++) prod_q[k] <= prod_d[k];
            end
        end
    end

    conv3x3_adder_tree #(
        .P_W   (P_W),
        .OUT_W (OUT_W)
    ) u_tree (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_eol    (s1_eol),
        .in_eof    (s1_eof),
        .prod      (prod_q),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_eol   (out_eol),
        .out_eof   (out_eof)
    );

endmodule

// File: tb/tb_conv3x3_mac.sv
// Directed bench for conv3x3_mac: a 20-bit output instance and a 16-bit saturating instance.
module tb_conv3x3_mac;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sof = 1'b0;
    logic        win_valid = 1'b0;
    logic [71:0] win_data = '0;
    logic        coef_load = 1'b0;
    logic signed [7:0] coef_data = '0;

    logic              coef_ready, out_valid, out_eol, out_eof, drop_err, state;
    logic signed [19:0] out_data;
    logic              coef_ready_16, out_valid_16, out_eol_16, out_eof_16, drop_err_16, state_16;
    logic signed [15:0] out_data_16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv3x3_mac #(.input_y(6), .DATA_W(8), .COEF_W(8), .OUT_W(20)) dut (
        .clk(clk), .rst(rst), .sof(sof), .win_valid(win_valid), .win_data(win_data),
        .coef_load(coef_load), .coef_data(coef_data), .coef_ready(coef_ready),
        .out_valid(out_valid), .out_data(out_data), .out_eol(out_eol), .out_eof(out_eof),
        .drop_err(drop_err), .state(state)
    );

    conv3x3_mac #(.input_y(6), .DATA_W(8), .COEF_W(8), .OUT_W(16)) dut16 (
        .clk(clk), .rst(rst), .sof(sof), .win_valid(win_valid), .win_data(win_data),
        .coef_load(coef_load), .coef_data(coef_data), .coef_ready(coef_ready_16),
        .out_valid(out_valid_16), .out_data(out_data_16), .out_eol(out_eol_16), .out_eof(out_eof_16),
        .drop_err(drop_err_16), .state(state_16)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_kernel(input logic [71:0] kern);
        for (int k = 0; k < 9; k++) begin
            coef_load = 1'b1;
            coef_data = kern[k*8 +: 8];
            @(negedge clk);
        end
        coef_load = 1'b0;
    endtask

    task automatic send_and_check(input string tag, input logic [71:0] pix,
                                  input logic signed [63:0] exp20, input logic signed [63:0] exp16);
        win_valid = 1'b1;
        win_data  = pix;
        @(negedge clk);
        win_valid = 1'b0;
        chk({tag, "_lat1"}, out_valid, 0);
        @(negedge clk);
        chk({tag, "_lat2"}, out_valid, 0);
        @(negedge clk);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_data"}, out_data, exp20);
        chk({tag, "_data16"}, out_data_16, exp16);
        @(negedge clk);
        chk({tag, "_gap"}, out_valid, 0);
        chk({tag, "_hold"}, out_data, exp20);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [71:0] kv;
        logic [71:0] pix19;
        int r;
        pix19 = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};

        repeat (3) @(negedge clk);
        chk("rst_ready", coef_ready, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_state", state, 0);
        chk("rst_drop", drop_err, 0);
        rst = 1'b1;
        @(negedge clk);

        // Window before any kernel: dropped, flagged.
        win_valid = 1'b1;
        win_data  = pix19;
        @(negedge clk);
        win_valid = 1'b0;
        repeat (4) begin
            chk("drop_noout", out_valid, 0);
            @(negedge clk);
        end
        chk("drop_err", drop_err, 1);

        kv = {8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int k = 0; k < 9; k++) begin
            if (k == 8) chk("ready_pre9", coef_ready, 0);
            coef_load = 1'b1;
            coef_data = kv[k*8 +: 8];
            @(negedge clk);
        end
        coef_load = 1'b0;
        chk("ready_post9", coef_ready, 1);
        chk("state_run", state, 1);

        sof = 1'b1;
        send_and_check("ident", pix19, 5, 5);
        sof = 1'b0;

        load_kernel({8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
        send_and_check("ramp", pix19, 285, 285);

        load_kernel({8'h01, 8'h00, 8'hFF, 8'h02, 8'h00, 8'hFE, 8'h01, 8'h00, 8'hFF});
        send_and_check("sobel", pix19, 8, 8);

        load_kernel({9{8'h01}});
        send_and_check("ones255", {9{8'hFF}}, 2295, 2295);

        load_kernel({9{8'h80}});
        send_and_check("neg128", {9{8'hFF}}, -293760, -32768);

        load_kernel({9{8'h7F}});
        send_and_check("pos127", {9{8'hFF}}, 291465, 32767);

        // Back-to-back stream; window c carries pixel value c+1 under the all-ones kernel.
        load_kernel({9{8'h01}});
        for (int c = 0; c < 23; c++) begin
            if (c >= 3) begin
                r = c - 3;
                chk("strm_valid", out_valid, 1);
                chk("strm_data", out_data, 9 * (r + 1));
                chk("strm_eol", out_eol, (r % 4) == 3);
                chk("strm_eof", out_eof, r == 15);
            end else begin
                chk("strm_idle", out_valid, 0);
            end
            if (c < 20) begin
                sof       = (c == 0);
                win_valid = 1'b1;
                win_data  = {9{8'(c + 1)}};
            end else begin
                sof       = 1'b0;
                win_valid = 1'b0;
            end
            @(negedge clk);
        end

        // Reload to all-twos while two windows are in flight under all-ones.
        for (int c = 0; c < 12; c++) begin
            if (c == 3) begin
                chk("reload_v0", out_valid, 1);
                chk("reload_old0", out_data, 45);
            end
            if (c == 4) begin
                chk("reload_v1", out_valid, 1);
                chk("reload_old1", out_data, 90);
            end
            if (c == 5) begin
                chk("reload_ready", coef_ready, 0);
                chk("reload_state", state, 0);
                chk("reload_quiet", out_valid, 0);
            end
            win_valid = (c < 2);
            win_data  = (c == 0) ? {9{8'd5}} : {9{8'd10}};
            coef_load = (c >= 1) && (c <= 9);
            coef_data = ((c >= 1) && (c <= 9)) ? 8'sd2 : 8'sd0;
            @(negedge clk);
        end
        win_valid = 1'b0;
        coef_load = 1'b0;
        chk("reload_done", coef_ready, 1);
        send_and_check("newk", {9{8'd10}}, 180, 180);

        // Reset with two windows still inside the pipeline.
        win_valid = 1'b1;
        win_data  = {9{8'd7}};
        @(negedge clk);
        win_data  = {9{8'd8}};
        @(negedge clk);
        win_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_eol", out_eol, 0);
        chk("arst_state", state, 0);
        chk("arst_ready", coef_ready, 0);
        chk("arst_drop", drop_err, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            chk("arst_nostale", out_valid, 0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
